// File: rtl/ipv4_rx_header_pkg.sv
// rtl/ipv4_rx_header_pkg.sv - shared constants, state type and checksum helper for the IPv4 RX header parser
package ipv4_rx_header_pkg;

    localparam int BYTE_LEN     = 8;
    localparam int IPV4_VERSION = 4;
    localparam int IPV4_MIN_IHL = 5;

    localparam int OFF_TOTLEN = 2;
    localparam int OFF_PROTO  = 9;
    localparam int OFF_SRC    = 12;
    localparam int OFF_DST    = 16;

    localparam int ERR_CSUM = 0;
    localparam int ERR_VER  = 1;
    localparam int ERR_LEN  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] w);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, w};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/ipv4_csum_acc.sv
// rtl/ipv4_csum_acc.sv - byte-pair word assembler with end-around-carry one's-complement accumulator
module ipv4_csum_acc
    import ipv4_rx_header_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        odd,
    input  logic [7:0]  data,
    output logic [15:0] sum
);
    logic [7:0]  hi;
    logic [15:0] acc;

    // sum already includes a word completing this cycle, so a verdict can be registered alongside it
    always_comb begin
        sum = acc;
        if (clr)
            sum = 16'h0000;
        else if (en && odd)
            sum = ones_add(acc, {hi, data});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= 16'h0000;
            hi  <= 8'h00;
        end else begin
            acc <= sum;
            if (en && !odd)
                hi <= data;
        end
    end

endmodule

// File: rtl/ipv4_rx_header.sv
// rtl/ipv4_rx_header.sv - byte-serial IPv4 header parser, checksum verifier and payload forwarder
module ipv4_rx_header
    import ipv4_rx_header_pkg::*;
#(
    parameter int MAX_IHL = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inclk,
    input  logic [BYTE_LEN-1:0] in,
    input  logic                sof,
    output logic                hdr_done,
    output logic                hdr_ok,
    output logic [2:0]          hdr_err,
    output logic [3:0]          ihl,
    output logic [15:0]         total_len,
    output logic [7:0]          protocol,
    output logic [31:0]         src_ip,
    output logic [31:0]         dst_ip,
    output logic                outclk,
    output logic [BYTE_LEN-1:0] out,
    output logic                out_last
);
    localparam int CNT_W = $clog2(4 * MAX_IHL);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cur_ver, cur_ihl;
    logic [15:0]      cur_len, remaining;
    logic [7:0]       cur_proto;
    logic [31:0]      cur_src, cur_dst;

    logic             start, hdr_byte, pay_byte, pay_last, last_hdr, short_hdr, odd, verdict_ok;
    logic [CNT_W-1:0] hdr_last_idx;
    logic [15:0]      hdr_len16, len_nx, csum;
    logic [31:0]      dst_nx;
    logic [2:0]       err_nx;

    ipv4_csum_acc u_csum (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .en   (start | hdr_byte),
        .odd  (odd),
        .data (in),
        .sum  (csum)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start)
            state_nx = ST_HDR;
        else if (last_hdr) begin
            if (!verdict_ok)
                state_nx = ST_DROP;
            else if (len_nx == hdr_len16)
                state_nx = ST_IDLE;
            else
                state_nx = ST_PAYLOAD;
        end else if (pay_last)
            state_nx = ST_IDLE;
    end

    // Byte classification and header verdict; a short IHL ends the header once total_len is known
    always_comb begin
        start        = inclk && sof;
        hdr_byte     = inclk && !sof && (state == ST_HDR);
        pay_byte     = inclk && !sof && (state == ST_PAYLOAD);
        pay_last     = pay_byte && (remaining == 16'd1);
        odd          = !start && cnt[0];
        short_hdr    = cur_ihl < 4'(IPV4_MIN_IHL);
        hdr_len16    = {10'd0, cur_ihl, 2'b00};
        hdr_last_idx = short_hdr ? CNT_W'(OFF_TOTLEN + 1) : CNT_W'(hdr_len16 - 16'd1);
        last_hdr     = hdr_byte && (cnt == hdr_last_idx);

        len_nx = cur_len;
        if (hdr_byte && cnt == CNT_W'(OFF_TOTLEN))
            len_nx[15:8] = in;
        if (hdr_byte && cnt == CNT_W'(OFF_TOTLEN + 1))
            len_nx[7:0] = in;

        dst_nx = cur_dst;
        if (hdr_byte && cnt >= CNT_W'(OFF_DST) && cnt < CNT_W'(OFF_DST + 4))
            dst_nx = {cur_dst[23:0], in};

        err_nx           = 3'b000;
        err_nx[ERR_CSUM] = !short_hdr && (csum != 16'hFFFF);
        err_nx[ERR_VER]  = cur_ver != 4'(IPV4_VERSION);
        err_nx[ERR_LEN]  = short_hdr || (len_nx < hdr_len16);
        verdict_ok       = (err_nx == 3'b000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cur_ver   <= 4'd0;
            cur_ihl   <= 4'd0;
            cur_len   <= 16'd0;
            cur_proto <= 8'd0;
            cur_src   <= 32'd0;
            cur_dst   <= 32'd0;
            remaining <= 16'd0;
            hdr_done  <= 1'b0;
            hdr_ok    <= 1'b0;
            hdr_err   <= 3'b000;
            ihl       <= 4'd0;
            total_len <= 16'd0;
            protocol  <= 8'd0;
            src_ip    <= 32'd0;
            dst_ip    <= 32'd0;
            outclk    <= 1'b0;
            out       <= '0;
            out_last  <= 1'b0;
        end else begin
            hdr_done <= 1'b0;
            outclk   <= 1'b0;
            out_last <= 1'b0;
            if (start) begin
                cnt       <= CNT_W'(1);
                cur_ver   <= in[7:4];
                cur_ihl   <= in[3:0];
                cur_len   <= 16'd0;
                cur_proto <= 8'd0;
                cur_src   <= 32'd0;
                cur_dst   <= 32'd0;
            end else if (hdr_byte) begin
                cnt     <= cnt + CNT_W'(1);
                cur_len <= len_nx;
                cur_dst <= dst_nx;
                if (cnt == CNT_W'(OFF_PROTO))
                    cur_proto <= in;
                if (cnt >= CNT_W'(OFF_SRC) && cnt < CNT_W'(OFF_SRC + 4))
                    cur_src <= {cur_src[23:0], in};
            end
            if (last_hdr) begin
                hdr_done  <= 1'b1;
                hdr_ok    <= verdict_ok;
                hdr_err   <= err_nx;
                ihl       <= cur_ihl;
                total_len <= len_nx;
                protocol  <= cur_proto;
                src_ip    <= cur_src;
                dst_ip    <= dst_nx;
                remaining <= len_nx - hdr_len16;
            end
            if (pay_byte) begin
                outclk    <= 1'b1;
                out       <= in;
                out_last  <= pay_last;
                remaining <= remaining - 16'd1;
            end
        end
    end

endmodule
